// File: rtl/dat_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dat_xfer_ctrl_if
//  Purpose  : Bundles the command, FIFO-status, datapath-handshake and
//             status signals of the SD DAT transfer sequencer.
//  Modports : master - register block / physical-layer side (drives inputs)
//             slave  - dat_xfer_ctrl side
//  Signals  : start, dir_rd, multiple_in, block_sz_in, block_cnt_in,
//             timeout_val, abort, tx_fifo_empty, rx_fifo_full, tx_buf_rd_enb,
//             rx_buf_wr_enb, dat_phys_busy, tf_finished      (to sequencer)
//             write_flag, read_flag, multiple, block_sz, block_cnt,
//             phys_rst_req, ctrl_busy, xfer_done, tout_err, param_err,
//             xfer_words                                      (from sequencer)
//  Revision : 1.0 - initial release
// ============================================================================
interface dat_xfer_ctrl_if #(
  parameter int BLOCK_SZ_W  = 12,
  parameter int BLOCK_CNT_W = 16,
  parameter int TOUT_W      = 16,
  parameter int WCNT_W      = 20
) ();
  logic                   start;
  logic                   dir_rd;
  logic                   multiple_in;
  logic [BLOCK_SZ_W-1:0]  block_sz_in;
  logic [BLOCK_CNT_W-1:0] block_cnt_in;
  logic [TOUT_W-1:0]      timeout_val;
  logic                   abort;
  logic                   tx_fifo_empty;
  logic                   rx_fifo_full;
  logic                   tx_buf_rd_enb;
  logic                   rx_buf_wr_enb;
  logic                   dat_phys_busy;
  logic                   tf_finished;
  logic                   write_flag;
  logic                   read_flag;
  logic                   multiple;
  logic [BLOCK_SZ_W-1:0]  block_sz;
  logic [BLOCK_CNT_W-1:0] block_cnt;
  logic                   phys_rst_req;
  logic                   ctrl_busy;
  logic                   xfer_done;
  logic                   tout_err;
  logic                   param_err;
  logic [WCNT_W-1:0]      xfer_words;

  modport master (
    output start, dir_rd, multiple_in, block_sz_in, block_cnt_in, timeout_val,
           abort, tx_fifo_empty, rx_fifo_full, tx_buf_rd_enb, rx_buf_wr_enb,
           dat_phys_busy, tf_finished,
    input  write_flag, read_flag, multiple, block_sz, block_cnt, phys_rst_req,
           ctrl_busy, xfer_done, tout_err, param_err, xfer_words
  );

  modport slave (
    input  start, dir_rd, multiple_in, block_sz_in, block_cnt_in, timeout_val,
           abort, tx_fifo_empty, rx_fifo_full, tx_buf_rd_enb, rx_buf_wr_enb,
           dat_phys_busy, tf_finished,
    output write_flag, read_flag, multiple, block_sz, block_cnt, phys_rst_req,
           ctrl_busy, xfer_done, tout_err, param_err, xfer_words
  );
endinterface
`default_nettype wire

// File: rtl/dat_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dat_xfer_ctrl
//  Purpose  : SD host DAT transfer sequencer. Latches a transfer command,
//             drives the physical layer's write/read flags gated by FIFO
//             status, counts moved words, and reports completion, parameter
//             errors and data timeouts. Abort or timeout requests a 2-cycle
//             physical-layer reset.
//  Ports    : sd_clk - sole clock (rising edge)
//             rst    - synchronous active-high reset
//             bus    - dat_xfer_ctrl_if.slave (command, FIFO status,
//                      handshakes in; flags, latched params, status out)
//  Revision : 1.0 - initial release
// ============================================================================
module dat_xfer_ctrl #(
  parameter int BLOCK_SZ_W  = 12,
  parameter int BLOCK_CNT_W = 16,
  parameter int TOUT_W      = 16,
  parameter int WCNT_W      = 20
) (
  input  logic            sd_clk,
  input  logic            rst,
  dat_xfer_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_ABORT  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]             state_q,     state_d;
  logic                   dir_q,       dir_d;
  logic                   mult_q,      mult_d;
  logic [BLOCK_SZ_W-1:0]  bsz_q,       bsz_d;
  logic [BLOCK_CNT_W-1:0] bcnt_q,      bcnt_d;
  logic [TOUT_W-1:0]      tout_q,      tout_d;
  logic [WCNT_W-1:0]      words_q,     words_d;
  logic [1:0]             arst_cnt_q,  arst_cnt_d;
  logic                   param_err_q, param_err_d;
  logic                   tout_err_q,  tout_err_d;
  logic                   busy_q, done_q, prr_q;

  logic xfer_phase;  // LAUNCH or ACTIVE: flags driven, counters running
  logic any_hs;      // any datapath handshake (reloads the timeout)
  logic word_hs;     // handshake belonging to the latched direction
  logic expire;
  logic bad_param;

  assign xfer_phase = (state_q == S_LAUNCH) || (state_q == S_ACTIVE);
  assign any_hs     = bus.tx_buf_rd_enb | bus.rx_buf_wr_enb;
  assign word_hs    = dir_q ? bus.rx_buf_wr_enb : bus.tx_buf_rd_enb;
  // A handshake or end-of-transfer in the last counted cycle wins over expiry.
  assign expire     = (tout_q == TOUT_W'(1)) & ~any_hs & ~bus.tf_finished;
  assign bad_param  = (bus.block_sz_in == '0) || (bus.block_sz_in[1:0] != 2'b00) ||
                      (bus.block_cnt_in == '0);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    mult_d      = mult_q;
    bsz_d       = bsz_q;
    bcnt_d      = bcnt_q;
    tout_d      = tout_q;
    words_d     = words_q;
    arst_cnt_d  = arst_cnt_q;
    param_err_d = 1'b0;
    tout_err_d  = 1'b0;

    // Zero stays zero, so timeout_val == 0 never reaches the expiry value.
    if (any_hs) begin
      tout_d = bus.timeout_val;
    end else if (xfer_phase && (tout_q != '0)) begin
      tout_d = tout_q - TOUT_W'(1);
    end

    if (xfer_phase && word_hs && (words_q != '1)) begin
      words_d = words_q + WCNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bad_param) begin
            param_err_d = 1'b1;
          end else begin
            dir_d   = bus.dir_rd;
            mult_d  = bus.multiple_in;
            bsz_d   = bus.block_sz_in;
            bcnt_d  = bus.multiple_in ? bus.block_cnt_in : BLOCK_CNT_W'(1);
            words_d = '0;
            tout_d  = bus.timeout_val;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (bus.abort || expire) begin
          state_d    = S_ABORT;
          tout_err_d = ~bus.abort;
          arst_cnt_d = 2'd0;
        end else if (bus.dat_phys_busy) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (bus.tf_finished) begin
          state_d = S_DONE;
        end else if (bus.abort || expire) begin
          state_d    = S_ABORT;
          tout_err_d = ~bus.abort;
          arst_cnt_d = 2'd0;
        end
      end
      S_ABORT: begin
        // Two cycles in ABORT hold the physical-layer reset request.
        if (arst_cnt_q == 2'd1) begin
          state_d = S_IDLE;
        end else begin
          arst_cnt_d = arst_cnt_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      mult_q      <= 1'b0;
      bsz_q       <= '0;
      bcnt_q      <= '0;
      tout_q      <= '0;
      words_q     <= '0;
      arst_cnt_q  <= 2'd0;
      param_err_q <= 1'b0;
      tout_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      mult_q      <= mult_d;
      bsz_q       <= bsz_d;
      bcnt_q      <= bcnt_d;
      tout_q      <= tout_d;
      words_q     <= words_d;
      arst_cnt_q  <= arst_cnt_d;
      param_err_q <= param_err_d;
      tout_err_q  <= tout_err_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      prr_q       <= (state_d == S_ABORT);
    end
  end

  // Flags stay combinational so FIFO status gates them in the same cycle.
  assign bus.write_flag   = xfer_phase & ~dir_q & ~bus.tx_fifo_empty;
  assign bus.read_flag    = xfer_phase &  dir_q & ~bus.rx_fifo_full;
  assign bus.multiple     = mult_q;
  assign bus.block_sz     = bsz_q;
  assign bus.block_cnt    = bcnt_q;
  assign bus.phys_rst_req = prr_q;
  assign bus.ctrl_busy    = busy_q;
  assign bus.xfer_done    = done_q;
  assign bus.tout_err     = tout_err_q;
  assign bus.param_err    = param_err_q;
  assign bus.xfer_words   = words_q;

endmodule
`default_nettype wire

// File: tb/tb_dat_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dat_xfer_ctrl
//  Purpose  : Self-checking bench for dat_xfer_ctrl: a table of per-cycle
//             vectors followed by hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dat_xfer_ctrl;
  localparam int BSW = 12;
  localparam int BCW = 16;
  localparam int TW  = 16;
  localparam int WW  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dat_xfer_ctrl_if #(.BLOCK_SZ_W(BSW), .BLOCK_CNT_W(BCW), .TOUT_W(TW), .WCNT_W(WW)) bus ();

  dat_xfer_ctrl #(.BLOCK_SZ_W(BSW), .BLOCK_CNT_W(BCW), .TOUT_W(TW), .WCNT_W(WW)) dut (
    .sd_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_vec       = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int wf_idle     = 0;

  // in = {start,dir_rd,multiple_in}_{abort,tx_empty,rx_full}_{pop,push,phys_busy,tf}
  // ex = {write_flag,read_flag}_{ctrl_busy,xfer_done}_{param_err,tout_err,phys_rst_req}
  // Flags are checked before the edge, everything else after it.
  typedef struct {
    string           nm;
    logic [9:0]      in;
    logic [BSW-1:0]  bsz;
    logic [BCW-1:0]  bcnt;
    logic [6:0]      ex;
    logic [WW-1:0]   words;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mkv(string nm, logic [9:0] in, logic [BSW-1:0] bsz,
                               logic [BCW-1:0] bcnt, logic [6:0] ex, logic [WW-1:0] words);
    vec_t v;
    v.nm = nm; v.in = in; v.bsz = bsz; v.bcnt = bcnt; v.ex = ex; v.words = words;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {bus.start, bus.dir_rd, bus.multiple_in, bus.abort, bus.tx_fifo_empty, bus.rx_fifo_full,
     bus.tx_buf_rd_enb, bus.rx_buf_wr_enb, bus.dat_phys_busy, bus.tf_finished} = '0;
    bus.block_sz_in  = 12'd512;
    bus.block_cnt_in = 16'd1;
    bus.timeout_val  = '0;
  endtask

  // Idle-state observer: busy low means IDLE, where write_flag must stay low.
  always @(negedge clk) begin
    if (bus.xfer_done) done_cnt++;
    if (!bus.ctrl_busy && bus.write_flag) wf_idle++;
  end

  initial begin
    int k;
    int bad;
    logic rxf;
    clr();
    repeat (3) tick();
    chk("rst_busy", bus.ctrl_busy, 0);
    chk("rst_prr", bus.phys_rst_req, 0);
    chk("rst_bsz", bus.block_sz, 0);
    chk("rst_bcnt", bus.block_cnt, 0);
    chk("rst_words", bus.xfer_words, 0);
    rst = 1'b0;

    tbl.push_back(mkv("idle",        10'b000_000_0000, 12'd512, 16'd1, 7'b00_00_000, 20'd0));
    tbl.push_back(mkv("perr_bsz0",   10'b100_000_0000, 12'd0,   16'd1, 7'b00_00_100, 20'd0));
    tbl.push_back(mkv("idle2",       10'b000_000_0000, 12'd512, 16'd1, 7'b00_00_000, 20'd0));
    tbl.push_back(mkv("perr_bsz6",   10'b100_000_0000, 12'd6,   16'd1, 7'b00_00_100, 20'd0));
    tbl.push_back(mkv("idle3",       10'b000_000_0000, 12'd512, 16'd1, 7'b00_00_000, 20'd0));
    tbl.push_back(mkv("perr_cnt0",   10'b101_000_0000, 12'd512, 16'd0, 7'b00_00_100, 20'd0));
    tbl.push_back(mkv("idle4",       10'b000_000_0000, 12'd512, 16'd1, 7'b00_00_000, 20'd0));
    tbl.push_back(mkv("wr_start",    10'b100_000_0000, 12'd8,   16'd5, 7'b00_10_000, 20'd0));
    tbl.push_back(mkv("wr_launch",   10'b000_000_0010, 12'd8,   16'd5, 7'b10_10_000, 20'd0));
    tbl.push_back(mkv("wr_txempty",  10'b000_010_1010, 12'd8,   16'd5, 7'b00_10_000, 20'd1));
    tbl.push_back(mkv("wr_pop",      10'b000_000_1010, 12'd8,   16'd5, 7'b10_10_000, 20'd2));
    tbl.push_back(mkv("abort_tf",    10'b000_100_0011, 12'd8,   16'd5, 7'b10_11_000, 20'd2));
    tbl.push_back(mkv("done",        10'b000_000_0000, 12'd8,   16'd5, 7'b00_00_000, 20'd2));
    tbl.push_back(mkv("rd_start",    10'b111_000_0000, 12'd4,   16'd2, 7'b00_10_000, 20'd0));
    tbl.push_back(mkv("rd_rxfull",   10'b000_001_0000, 12'd4,   16'd2, 7'b00_10_000, 20'd0));
    tbl.push_back(mkv("rd_push",     10'b000_000_0100, 12'd4,   16'd2, 7'b01_10_000, 20'd1));
    tbl.push_back(mkv("start_ign",   10'b100_000_1010, 12'd0,   16'd0, 7'b01_10_000, 20'd1));
    tbl.push_back(mkv("abort",       10'b000_100_0010, 12'd4,   16'd2, 7'b01_10_001, 20'd1));
    tbl.push_back(mkv("abort_hold",  10'b000_000_0010, 12'd4,   16'd2, 7'b00_10_001, 20'd1));
    tbl.push_back(mkv("abort_end",   10'b000_000_0000, 12'd4,   16'd2, 7'b00_00_000, 20'd1));
    tbl.push_back(mkv("idle_hold",   10'b000_000_0000, 12'd4,   16'd2, 7'b00_00_000, 20'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      {bus.start, bus.dir_rd, bus.multiple_in, bus.abort, bus.tx_fifo_empty, bus.rx_fifo_full,
       bus.tx_buf_rd_enb, bus.rx_buf_wr_enb, bus.dat_phys_busy, bus.tf_finished} = tbl[i].in;
      bus.block_sz_in  = tbl[i].bsz;
      bus.block_cnt_in = tbl[i].bcnt;
      #1;
      chk({tbl[i].nm, ".wf"}, bus.write_flag, tbl[i].ex[6]);
      chk({tbl[i].nm, ".rf"}, bus.read_flag,  tbl[i].ex[5]);
      tick();
      chk({tbl[i].nm, ".busy"}, bus.ctrl_busy,    tbl[i].ex[4]);
      chk({tbl[i].nm, ".done"}, bus.xfer_done,    tbl[i].ex[3]);
      chk({tbl[i].nm, ".perr"}, bus.param_err,    tbl[i].ex[2]);
      chk({tbl[i].nm, ".terr"}, bus.tout_err,     tbl[i].ex[1]);
      chk({tbl[i].nm, ".prr"},  bus.phys_rst_req, tbl[i].ex[0]);
      chk({tbl[i].nm, ".words"}, bus.xfer_words,  tbl[i].words);
    end

    // Write, single block of 512 bytes: 128 pops then end-of-transfer.
    clr();
    bus.start = 1'b1; bus.block_cnt_in = 16'd7;
    tick();
    bus.start = 1'b0;
    chk("wr1_bcnt", bus.block_cnt, 1);
    chk("wr1_bsz", bus.block_sz, 512);
    chk("wr1_mult", bus.multiple, 0);
    bus.dat_phys_busy = 1'b1;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      bus.tx_buf_rd_enb = 1'b1;
      #1;
      if (bus.write_flag !== 1'b1) bad++;
      tick();
    end
    bus.tx_buf_rd_enb = 1'b0;
    chk("wr1_flag_bad", bad, 0);
    chk("wr1_words", bus.xfer_words, 128);
    bus.tf_finished = 1'b1;
    tick();
    bus.tf_finished = 1'b0; bus.dat_phys_busy = 1'b0;
    chk("wr1_done", bus.xfer_done, 1);
    tick();
    chk("wr1_done_end", bus.xfer_done, 0);
    chk("wr1_idle", bus.ctrl_busy, 0);

    // Read, 3 blocks, Rx FIFO full for 10 cycles inside the first block.
    clr();
    bus.start = 1'b1; bus.dir_rd = 1'b1; bus.multiple_in = 1'b1; bus.block_cnt_in = 16'd3;
    tick();
    bus.start = 1'b0;
    chk("rd3_bcnt", bus.block_cnt, 3);
    chk("rd3_mult", bus.multiple, 1);
    bus.dat_phys_busy = 1'b1;
    bad = 0;
    for (int i = 0; i < 394; i++) begin
      rxf = (i >= 100) && (i < 110);
      bus.rx_fifo_full  = rxf;
      bus.rx_buf_wr_enb = ~rxf;
      #1;
      if (bus.read_flag !== ~rxf) bad++;
      tick();
    end
    bus.rx_fifo_full = 1'b0; bus.rx_buf_wr_enb = 1'b0;
    chk("rd3_flag_bad", bad, 0);
    bus.tf_finished = 1'b1;
    tick();
    bus.tf_finished = 1'b0; bus.dat_phys_busy = 1'b0;
    chk("rd3_done", bus.xfer_done, 1);
    chk("rd3_words", bus.xfer_words, 384);
    tick();

    // Timeout: no handshake at all after launch.
    clr();
    bus.timeout_val = 16'd20; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while ((k < 40) && (bus.tout_err !== 1'b1)) begin
      tick();
      k++;
    end
    chk("tout_latency", k, 20);
    chk("tout_prr1", bus.phys_rst_req, 1);
    tick();
    chk("tout_prr2", bus.phys_rst_req, 1);
    chk("tout_pulse", bus.tout_err, 0);
    tick();
    chk("tout_prr_end", bus.phys_rst_req, 0);
    chk("tout_idle", bus.ctrl_busy, 0);

    // Handshake in the counter==1 cycle reloads instead of expiring.
    clr();
    bus.timeout_val = 16'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.dat_phys_busy = 1'b1;
    tick();
    tick();
    bus.tx_buf_rd_enb = 1'b1;
    tick();
    bus.tx_buf_rd_enb = 1'b0;
    chk("reload_no_tout", bus.tout_err, 0);
    chk("reload_busy", bus.ctrl_busy, 1);
    tick();
    tick();
    chk("reload_pre", bus.tout_err, 0);
    tick();
    chk("reload_tout", bus.tout_err, 1);
    bus.dat_phys_busy = 1'b0;
    tick();
    tick();
    chk("reload_idle", bus.ctrl_busy, 0);

    // Synchronous reset while ACTIVE.
    clr();
    bus.start = 1'b1; bus.multiple_in = 1'b1; bus.block_cnt_in = 16'd4;
    tick();
    bus.start = 1'b0; bus.dat_phys_busy = 1'b1;
    tick();
    bus.tx_buf_rd_enb = 1'b1;
    tick();
    bus.tx_buf_rd_enb = 1'b0;
    chk("mid_words", bus.xfer_words, 1);
    rst = 1'b1;
    tick();
    chk("mrst_wf", bus.write_flag, 0);
    chk("mrst_rf", bus.read_flag, 0);
    chk("mrst_busy", bus.ctrl_busy, 0);
    chk("mrst_pulses", {bus.xfer_done, bus.param_err, bus.tout_err, bus.phys_rst_req}, 0);
    chk("mrst_words", bus.xfer_words, 0);
    chk("mrst_bcnt", bus.block_cnt, 0);
    chk("mrst_mult", bus.multiple, 0);
    rst = 1'b0;
    bus.dat_phys_busy = 1'b0; bus.start = 1'b1; bus.block_sz_in = 12'd16;
    tick();
    bus.start = 1'b0;
    chk("mrst_restart", bus.ctrl_busy, 1);
    chk("mrst_bsz", bus.block_sz, 16);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    tick();
    chk("mrst_end_idle", bus.ctrl_busy, 0);

    chk("done_pulses", done_cnt, 3);
    chk("wf_in_idle", wf_idle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
